// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared state type and default parameters for the RO PUF evaluator
package ro_puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_COMPARE = 3'd3,
    ST_HOLD    = 3'd4
  } ro_eval_state_t;

  localparam int RO_WINDOW_DEFAULT = 4096;
  localparam int RO_SETTLE_DEFAULT = 16;
  localparam int RO_CNT_W_DEFAULT  = 16;

endpackage

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - synchronizes one RO output and counts its rising edges, saturating
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = RO_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_in,
  input  logic             clear,
  input  logic             count_en,
  output logic [CNT_W-1:0] count
);

  logic sync_1;
  logic sync_2;
  logic hist;
  logic rise;

  assign rise = sync_2 & ~hist;

  // Synchronizer and history run continuously so the first MEASURE cycle sees a valid history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      hist   <= 1'b0;
      count  <= '0;
    end else begin
      sync_1 <= ro_in;
      sync_2 <= sync_1;
      hist   <= sync_2;
      if (clear) begin
        count <= '0;
      end else if (count_en && rise && (count != '1)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ro_puf_evaluator.sv
// rtl/ro_puf_evaluator.sv - enables an RO pair, counts both over a window, compares into one response bit
module ro_puf_evaluator
  import ro_puf_pkg::*;
#(
  parameter int WINDOW_CYCLES = RO_WINDOW_DEFAULT,
  parameter int SETTLE_CYCLES = RO_SETTLE_DEFAULT,
  parameter int CNT_W         = RO_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             ro_enable,
  input  logic             ro_a_in,
  input  logic             ro_b_in,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_bit,
  output logic             resp_tie,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_SETTLE  = ST_SETTLE;
  localparam logic [2:0] S_MEASURE = ST_MEASURE;
  localparam logic [2:0] S_COMPARE = ST_COMPARE;
  localparam logic [2:0] S_HOLD    = ST_HOLD;

  localparam int PH_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [PH_W-1:0] phase;
  logic            phase_done;
  logic            accept;
  logic            counting;

  assign phase_done = (phase == '0);
  assign accept     = (state == S_IDLE) && start;
  assign counting   = (state == S_MEASURE);
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start)       state_nxt = S_SETTLE;
      S_SETTLE:  if (phase_done)  state_nxt = S_MEASURE;
      S_MEASURE: if (phase_done)  state_nxt = S_COMPARE;
      S_COMPARE:                  state_nxt = S_HOLD;
      S_HOLD:    if (resp_ready)  state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // Phase counts down remaining cycles of SETTLE, then is reloaded for the MEASURE window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase     <= '0;
      ro_enable <= 1'b0;
      resp_bit  <= 1'b0;
      resp_tie  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ro_enable <= (state_nxt == S_SETTLE) || (state_nxt == S_MEASURE);
      if (accept) begin
        phase <= PH_W'(SETTLE_CYCLES - 1);
      end else if ((state == S_SETTLE) && phase_done) begin
        phase <= PH_W'(WINDOW_CYCLES - 1);
      end else if (!phase_done && ((state == S_SETTLE) || (state == S_MEASURE))) begin
        phase <= phase - 1'b1;
      end
      if (accept) begin
        resp_bit <= 1'b0;
        resp_tie <= 1'b0;
      end else if (state == S_COMPARE) begin
        resp_bit <= (count_a > count_b);
        resp_tie <= (count_a == count_b);
      end
    end
  end

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .ro_in    (ro_a_in),
    .clear    (accept),
    .count_en (counting),
    .count    (count_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .ro_in    (ro_b_in),
    .clear    (accept),
    .count_en (counting),
    .count    (count_b)
  );

endmodule

// File: tb/tb_ro_puf_evaluator.sv
// tb/tb_ro_puf_evaluator.sv - self-checking bench for ro_puf_evaluator against a window/period model
`timescale 1ns/1ps
module tb_ro_puf_evaluator;

  localparam int S  = 16;
  localparam int W  = 400;
  localparam int SW = 100;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        ro_enable;
  logic        ro_a;
  logic        ro_b;
  logic        ro_b_mux;
  logic        follow_a;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_bit;
  logic        resp_tie;
  logic [15:0] count_a;
  logic [15:0] count_b;

  logic        s_start;
  logic        s_busy;
  logic        s_ro_enable;
  logic        s_ro_a;
  logic        s_ro_b;
  logic        s_resp_valid;
  logic        s_resp_ready;
  logic        s_resp_bit;
  logic        s_resp_tie;
  logic [3:0]  s_count_a;
  logic [3:0]  s_count_b;

  int checks = 0;
  int errors = 0;

  int half_a = 20;
  int half_b = 25;
  bit run_a  = 0;
  bit run_b  = 0;

  assign ro_b_mux = follow_a ? ro_a : ro_b;

  ro_puf_evaluator #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .ro_enable  (ro_enable),
    .ro_a_in    (ro_a),
    .ro_b_in    (ro_b_mux),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_bit   (resp_bit),
    .resp_tie   (resp_tie),
    .count_a    (count_a),
    .count_b    (count_b)
  );

  ro_puf_evaluator #(.WINDOW_CYCLES(SW), .SETTLE_CYCLES(S), .CNT_W(4)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s_start),
    .busy       (s_busy),
    .ro_enable  (s_ro_enable),
    .ro_a_in    (s_ro_a),
    .ro_b_in    (s_ro_b),
    .resp_valid (s_resp_valid),
    .resp_ready (s_resp_ready),
    .resp_bit   (s_resp_bit),
    .resp_tie   (s_resp_tie),
    .count_a    (s_count_a),
    .count_b    (s_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running RO models; half periods in ns (one clk = 10 ns).
  always begin
    if (run_a) begin
      #(half_a);
      if (run_a) ro_a = ~ro_a;
    end else #1;
  end

  always begin
    if (run_b) begin
      #(half_b);
      if (run_b) ro_b = ~ro_b;
    end else #1;
  end

  initial s_ro_a = 1'b0;
  always #20 s_ro_a = ~s_ro_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rising edges in a window of w cycles for period p lie within one edge of w/p.
  function automatic bit in_tol(input int cnt, input int w, input int p);
    return (cnt * p + p >= w) && (cnt * p <= w + p);
  endfunction

  task automatic set_ros(input int pa, input int pb, input bit follow);
    run_a = 0;
    run_b = 0;
    #20;
    ro_a     = 1'b0;
    ro_b     = 1'b0;
    follow_a = follow;
    half_a   = 5 * pa;
    half_b   = 5 * pb;
    @(posedge clk);
    #($urandom_range(4, 1));
    run_a = 1;
    run_b = 1;
  endtask

  task automatic eval_main(input int pa, input int pb, input bit follow,
                           input int hold_cycles, input bit poke);
    int  n;
    int  off_at;
    int  v_at;
    int  ca;
    int  cb;
    bit  rb;
    bit  rt;
    bit  stable;
    set_ros(pa, pb, follow);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_e0", 32'(busy), 32'd1);
    check("ro_en_after_e0", 32'(ro_enable), 32'd1);
    n = 0;
    off_at = -1;
    v_at = -1;
    while (v_at < 0 && n < 600) begin
      @(posedge clk);
      #1;
      n++;
      if (off_at < 0 && !ro_enable) off_at = n;
      if (resp_valid) v_at = n;
      start = poke && (n == 5 || n == 100);
    end
    start = 1'b0;
    check("ro_en_fall_edge", 32'(off_at), 32'(S + W));
    check("valid_rise_edge", 32'(v_at), 32'(S + W + 1));
    ca = int'(count_a);
    cb = int'(count_b);
    rb = resp_bit;
    rt = resp_tie;
    stable = 1;
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      start = poke && (i == 3);
      @(posedge clk);
      #1;
      if (!resp_valid || int'(count_a) != ca || int'(count_b) != cb ||
          resp_bit != rb || resp_tie != rt) stable = 0;
    end
    start = 1'b0;
    check("hold_stable", 32'(stable), 32'd1);
    @(negedge clk);
    resp_ready = 1'b1;
    start = poke;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    start = 1'b0;
    check("busy_after_hs", 32'(busy), 32'd0);
    check("valid_after_hs", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("start_not_queued", 32'(busy), 32'd0);
    check("count_a_held", 32'(count_a), 32'(ca));
    if (follow) begin
      check("tie_counts_equal", 32'(ca == cb), 32'd1);
      check("tie_flag", 32'(resp_tie), 32'd1);
      check("tie_bit", 32'(resp_bit), 32'd0);
      check("tie_count_tol", 32'(in_tol(ca, W, pa)), 32'd1);
    end else begin
      check("count_a_tol", 32'(in_tol(ca, W, pa)), 32'd1);
      check("count_b_tol", 32'(in_tol(cb, W, pb)), 32'd1);
      check("resp_bit_model", 32'(resp_bit), 32'(pa < pb));
      check("resp_tie_model", 32'(resp_tie), 32'd0);
      check("resp_bit_vs_counts", 32'(resp_bit), 32'(ca > cb));
    end
  endtask

  initial begin
    int n;
    int prev;
    bit mono;
    rst_n        = 1'b0;
    start        = 1'b0;
    resp_ready   = 1'b0;
    follow_a     = 1'b0;
    ro_a         = 1'b0;
    ro_b         = 1'b0;
    s_start      = 1'b0;
    s_ro_b       = 1'b0;
    s_resp_ready = 1'b0;
    run_a        = 1;
    run_b        = 1;

    // Reset held with inputs toggling.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start      = ~start;
      resp_ready = ~resp_ready;
      s_start    = ~s_start;
    end
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ro_en", 32'(ro_enable), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_bit_tie", 32'({resp_bit, resp_tie}), 32'd0);
    check("rst_counts", 32'({count_a, count_b}), 32'd0);
    check("rst_sat_outs", 32'({s_busy, s_ro_enable, s_resp_valid, s_count_a}), 32'd0);
    @(negedge clk);
    start      = 1'b0;
    resp_ready = 1'b0;
    s_start    = 1'b0;
    rst_n      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_outs", 32'({ro_enable, resp_valid, resp_bit, resp_tie, count_a, count_b}), 32'd0);

    // Directed: A period 8, B period 10, with backpressure and ignored start pulses.
    eval_main(8, 10, 1'b0, 20, 1'b1);
    // Identical in-phase waveforms.
    eval_main(6, 6, 1'b1, 2, 1'b0);

    // Randomized periods.
    for (int k = 0; k < 3; k++) begin
      int pa;
      int pb;
      int t;
      pa = 4 + 2 * int'($urandom_range(3, 0));
      pb = pa + 2 * int'($urandom_range(3, 1));
      if ($urandom_range(1, 0) == 1) begin
        t = pa; pa = pb; pb = t;
      end
      eval_main(pa, pb, 1'b0, int'($urandom_range(5, 0)), 1'b0);
    end

    // Reset mid-MEASURE, then a normal evaluation.
    set_ros(8, 10, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_ro_en", 32'(ro_enable), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_counts", 32'({count_a, count_b}), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_still_idle", 32'({busy, resp_valid}), 32'd0);
    eval_main(8, 10, 1'b0, 1, 1'b0);

    // Saturation at CNT_W=4.
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    n = 0;
    prev = 0;
    mono = 1;
    while (!s_resp_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (int'(s_count_a) < prev) mono = 0;
      prev = int'(s_count_a);
    end
    check("sat_valid_edge", 32'(n), 32'(S + SW + 1));
    check("sat_no_wrap", 32'(mono), 32'd1);
    check("sat_count_a", 32'(s_count_a), 32'd15);
    check("sat_count_b", 32'(s_count_b), 32'd0);
    check("sat_bit_tie", 32'({s_resp_bit, s_resp_tie}), 32'b10);
    @(negedge clk);
    s_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    s_resp_ready = 1'b0;
    check("sat_after_hs", 32'({s_busy, s_resp_valid}), 32'd0);
    check("sat_count_held", 32'(s_count_a), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_puf_evaluator.md
# ro_puf_evaluator

Measurement back-end for the ring-oscillator PUF: enables a pair of ring oscillators, counts rising edges of each over a fixed clock window, and compares the two counts to produce one PUF response bit. Sits between the RO pair, which it enables and reads, and the response collector upstream, which it serves over a valid/ready handshake. One evaluation per `start` pulse.

## Interface
- `WINDOW_CYCLES`, default 4096: length of the counting window, in clk cycles (≥1).
- `SETTLE_CYCLES`, default 16: cycles with ROs enabled before counting starts (≥1).
- `CNT_W`, default 16: width of each edge counter.

- `clk`  in  1: system clock. Single clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request an evaluation. Sampled only in IDLE.
- `busy`  out  1: high in any state other than IDLE.
- `ro_enable`  out  1: enable for both ring oscillators. Registered.
- `ro_a_in`  in  1: output of RO A. Asynchronous to clk.
- `ro_b_in`  in  1: output of RO B. Asynchronous to clk.
- `resp_valid`  out  1: response available.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_bit`  out  1: 1 iff count_a > count_b.
- `resp_tie`  out  1: 1 iff count_a == count_b.
- `count_a`  out  CNT_W: final edge count of RO A.
- `count_b`  out  CNT_W: final edge count of RO B.

## Operation
- Each RO input passes through a 2-FF synchronizer plus a history flop. A rising edge is detected when the synced value is 1 and the history value is 0. All of these flops reset to 0 and run continuously.
- The RO toggle rate must stay below f_clk/2. This is a system constraint; divide-by stages, if needed, sit outside this block.
- FSM states: IDLE, SETTLE, MEASURE, COMPARE, HOLD.
  - IDLE: on `start`=1, go to SETTLE, clear both counters, and load the phase counter.
  - SETTLE: `ro_enable`=1, no counting. After SETTLE_CYCLES cycles, go to MEASURE.
  - MEASURE: `ro_enable`=1. Each detected edge increments its counter, saturating at 2^CNT_W−1. After WINDOW_CYCLES cycles, go to COMPARE.
  - COMPARE: `ro_enable`=0, counters frozen. Register `resp_bit` and `resp_tie`, then go to HOLD.
  - HOLD: `resp_valid`=1. On `resp_valid && resp_ready`, go to IDLE.
- Edges detected outside MEASURE are discarded.
- `start` in any state other than IDLE is ignored and not queued. This includes the cycle in which HOLD completes its handshake.
- `count_a`, `count_b`, `resp_bit` and `resp_tie` hold their values from COMPARE until the next accepted `start`.
- Reset values are 0 for every output: `busy`, `ro_enable`, `resp_valid`, `resp_bit`, `resp_tie`, `count_a`, `count_b`. The FSM resets to IDLE.
- Reset asserted mid-operation aborts immediately: `ro_enable` drops asynchronously and no response is produced.

## Timing
- Edge 0 is the edge that samples `start`=1 in IDLE.
  - `ro_enable` and `busy` are high after edge 0.
  - MEASURE begins after edge SETTLE_CYCLES.
  - `ro_enable` is low after edge SETTLE_CYCLES+WINDOW_CYCLES.
  - `resp_valid` is high after edge SETTLE_CYCLES+WINDOW_CYCLES+1.
- `resp_valid`, once high, stays high with all response outputs stable until the handshake completes.
- After a handshake at edge h, `busy`=0 and `resp_valid`=0 after edge h. A new `start` is accepted at edge h+1 at the earliest.
- Synchronizer latency is 2–3 cycles. Edges arriving in the last cycles of the window may fall outside it; counts are accurate to ±1.

## Structure
- Shared package `ro_puf_pkg` holds:
  - the state enum `ro_eval_state_t`;
  - default constants `RO_WINDOW_DEFAULT`, `RO_SETTLE_DEFAULT`, `RO_CNT_W_DEFAULT`.
- Sub-module `ro_edge_counter`, instantiated twice (A, B). It contains the synchronizer, edge detector, and saturating counter. Ports: `clk`, `rst_n`, `ro_in`, `clear`, `count_en`, `count`.
- The top level holds the FSM, the phase counter (width clog2(max(SETTLE, WINDOW)+1)), and the comparator.

## Test plan
- Reset: hold `rst_n`=0 with inputs toggling → all outputs are 0. Release, then idle 10 cycles → still 0, `busy`=0.
- Parameters S=16, W=400; RO A period 8 clk, RO B period 10 clk; pulse `start` → `count_a`=50±1, `count_b`=40±1, `resp_bit`=1, `resp_tie`=0, `resp_valid` rises after edge 417.
- Identical in-phase RO waveforms, period 6 → `count_a`==`count_b`, `resp_tie`=1, `resp_bit`=0.
- Saturation with CNT_W=4, RO A period 4, W=100 → `count_a`=15 and stays at 15, no wrap.
- Backpressure: `resp_ready`=0 for 20 cycles → `resp_valid` and the response stay stable. `start` pulses during SETTLE, MEASURE and HOLD are ignored. After the handshake, the next `start` runs exactly one new evaluation.
- Reset mid-MEASURE → `ro_enable`=0 immediately, counts are 0, no `resp_valid`. A subsequent `start` completes normally with correct counts.
